// File: rtl/fetch_pc_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_generator_if
// Description : Bus bundle between the fetch PC generator and its neighbours:
//               predictor / controller / execute inputs, instruction-memory
//               port, fetch/decode register outputs and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_generator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  isBranchTakenPredicted;
  logic                  stall;
  logic                  isBranch;
  logic                  isBranchMispredicted;
  logic [ADDR_WIDTH-1:0] redirectPC;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [31:0]           imemInst;
  logic                  fdValid;
  logic [ADDR_WIDTH-1:0] fdPC;
  logic [31:0]           fdInst;
  logic                  fdPredictedTaken;
  logic [ADDR_WIDTH-1:0] fdPredictedTarget;
  logic [CNT_WIDTH-1:0]  branchCount;
  logic [CNT_WIDTH-1:0]  mispredictCount;

  // Fetch-stage side: consumes control/memory inputs, produces fetch outputs.
  modport master (
    input  isBranchTakenPredicted,
    input  stall,
    input  isBranch,
    input  isBranchMispredicted,
    input  redirectPC,
    input  imemInst,
    output imemAddr,
    output fdValid,
    output fdPC,
    output fdInst,
    output fdPredictedTaken,
    output fdPredictedTarget,
    output branchCount,
    output mispredictCount
  );

  // Environment side: drives control/memory, observes fetch outputs.
  modport slave (
    output isBranchTakenPredicted,
    output stall,
    output isBranch,
    output isBranchMispredicted,
    output redirectPC,
    output imemInst,
    input  imemAddr,
    input  fdValid,
    input  fdPC,
    input  fdInst,
    input  fdPredictedTaken,
    input  fdPredictedTarget,
    input  branchCount,
    input  mispredictCount
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_generator.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_generator
// Description : Fetch-stage PC register with static pre-decode (JAL always
//               taken, conditional branches follow the predictor), redirect
//               on misprediction, fetch/decode pipeline register and
//               branch / misprediction performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_generator #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_generator_if.master bus
);

  localparam logic [6:0]            c_op_branch = 7'b1100011;
  localparam logic [6:0]            c_op_jal    = 7'b1101111;
  localparam logic [ADDR_WIDTH-1:0] c_pc_step   = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  c_cnt_one   = CNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_fd_valid;
  logic [ADDR_WIDTH-1:0] r_fd_pc;
  logic [31:0]           r_fd_inst;
  logic                  r_fd_pred_taken;
  logic [ADDR_WIDTH-1:0] r_fd_pred_target;
  logic [CNT_WIDTH-1:0]  r_branch_count;
  logic [CNT_WIDTH-1:0]  r_mispredict_count;

  logic [6:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_imm_b;
  logic [ADDR_WIDTH-1:0] w_imm_j;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  w_pred_taken;

  // Immediates are sign-extended straight to the PC width so that the
  // target adds wrap silently modulo 2^ADDR_WIDTH.
  assign w_opcode = bus.imemInst[6:0];
  assign w_imm_b  = {{(ADDR_WIDTH-12){bus.imemInst[31]}}, bus.imemInst[7],
                     bus.imemInst[30:25], bus.imemInst[11:8], 1'b0};
  assign w_imm_j  = {{(ADDR_WIDTH-20){bus.imemInst[31]}}, bus.imemInst[19:12],
                     bus.imemInst[20], bus.imemInst[30:21], 1'b0};

  // Next-PC choice: JAL always taken, BRANCH follows predictor, else pc+4.
  always_comb begin
    w_next_pc    = r_pc + c_pc_step;
    w_pred_taken = 1'b0;
    if (w_opcode == c_op_jal) begin
      w_next_pc    = r_pc + w_imm_j;
      w_pred_taken = 1'b1;
    end else if ((w_opcode == c_op_branch) && bus.isBranchTakenPredicted) begin
      w_next_pc    = r_pc + w_imm_b;
      w_pred_taken = 1'b1;
    end
  end

  // PC and fetch/decode register: reset > redirect (even if stalled) > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_fd_valid       <= 1'b0;
      r_fd_pc          <= '0;
      r_fd_inst        <= '0;
      r_fd_pred_taken  <= 1'b0;
      r_fd_pred_target <= '0;
    end else if (bus.isBranchMispredicted) begin
      r_pc       <= bus.redirectPC;
      r_fd_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc             <= w_next_pc;
      r_fd_valid       <= 1'b1;
      r_fd_pc          <= r_pc;
      r_fd_inst        <= bus.imemInst;
      r_fd_pred_taken  <= w_pred_taken;
      r_fd_pred_target <= w_next_pc;
    end
  end

  // Performance counters run regardless of stall and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (bus.isBranch) begin
        r_branch_count <= r_branch_count + c_cnt_one;
      end
      if (bus.isBranchMispredicted) begin
        r_mispredict_count <= r_mispredict_count + c_cnt_one;
      end
    end
  end

  assign bus.imemAddr          = r_pc;
  assign bus.fdValid           = r_fd_valid;
  assign bus.fdPC              = r_fd_pc;
  assign bus.fdInst            = r_fd_inst;
  assign bus.fdPredictedTaken  = r_fd_pred_taken;
  assign bus.fdPredictedTarget = r_fd_pred_target;
  assign bus.branchCount       = r_branch_count;
  assign bus.mispredictCount   = r_mispredict_count;

endmodule
`default_nettype wire
